retirement_rat: RTL and testbench
=================================

Name: retirement_rat

Overview:
- Commit-side stage fed by the ROB's per-cycle commit bundle (up to SS entries, oldest first).
- Holds the retirement register alias table (RRAT), mapping architectural regs to committed physical regs.
- Returns each overwritten physical reg to the free list.
- On a ROB flush, publishes the committed map one cycle later so the front-end RAT and free list can be restored.

Parameters:
- SS, 2, commit width (slots per cycle, slot 0 oldest).
- ARCH_REGS, 32, architectural register count; x0 never renamed.
- PHYS_REGS, 64, physical register count; must be >= ARCH_REGS + 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- commit_valid  in  [SS]x1  slot retires this cycle.
- commit_regf_we  in  [SS]x1  slot writes a destination reg.
- commit_rd  in  [SS]x$clog2(ARCH_REGS)  architectural destination.
- commit_pd  in  [SS]x$clog2(PHYS_REGS)  physical destination allocated at rename.
- flush  in  1  ROB mispredict flush; same cycle as the flushing instruction's commit.
- free_valid  out  [SS]x1  registered; push freed reg to free list.
- free_preg  out  [SS]x$clog2(PHYS_REGS)  freed physical reg.
- restore_valid  out  1  registered one-cycle pulse after flush.
- restore_map  out  [ARCH_REGS]x$clog2(PHYS_REGS)  current RRAT contents; always driven, meaningful when restore_valid.

Behaviour:
- Reset (rst=1 at posedge):
  - map[i] <= i for all i.
  - free_valid <= 0, free_preg <= 0, restore_valid <= 0.
  - Reset mid-flush or mid-commit discards all pending updates.
- A slot is effective when commit_valid && commit_regf_we && commit_rd != 0. Non-effective slots change nothing and free nothing.
- Freed reg for effective slot k:
  - Default is the old mapping of commit_rd[k].
  - If an older effective slot j<k in the same cycle has the same rd, the freed reg is commit_pd of the youngest such j (intra-bundle forwarding), not the table value.
- Table update at posedge: map[rd] <= pd for every effective slot. If several slots target the same rd, the youngest slot wins.
- Latency: free_valid/free_preg assert exactly 1 cycle after commit and hold for 1 cycle. Slot order is preserved (free_valid[k] corresponds to commit slot k).
- Flush:
  - Commits presented in the flush cycle are applied (the mispredicting branch and older slots are architecturally committed).
  - Next cycle: restore_valid=1, and restore_map reflects the table including those commits.
  - free_valid for the flush-cycle commits still asserts.
- Back-to-back flushes produce back-to-back restore pulses.
- No handshake and no stall: the free list must accept SS pushes per cycle, and commit is never back-pressured.
- commit_pd == 0 with an effective slot is illegal. An assertion flags it in simulation.
- restore_map is a direct view of the table registers, with no extra latency.

Optional Feature:
- Macro RRAT_STATS_EN.
- When defined:
  - Adds output retired_cnt [63:0], incremented by the number of commit_valid slots each cycle.
  - Adds output freed_cnt [63:0], incremented by the number of effective slots.
  - Both reset to 0, saturate at all-ones, and update 1 cycle after commit.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- rv32i_types holds:
  - ARCH_REGS and PHYS_REGS constants.
  - typedef rrat_commit_t {valid, regf_we, rd, pd}, which the ROB packs from its commit entries.
  - typedef rrat_free_t {valid, preg}.
- Sub-module rrat_bundle_resolve: combinational per-slot freed-reg selection and youngest-wins write-enable generation. The main module owns the table, output registers and stats.

Test Plan:
- Reset, then commit slot0 rd=5 pd=40 -> next cycle free_valid[0]=1, free_preg[0]=5; map[5]=40.
- Same cycle: slot0 rd=7 pd=41, slot1 rd=7 pd=42 -> next cycle free_preg[0]=7, free_preg[1]=41; map[7]=42.
- Commit rd=0 pd=43 with regf_we=1, and commit rd=3 with regf_we=0 -> no free_valid; map unchanged.
- flush with slot0 rd=9 pd=50 -> next cycle restore_valid=1, restore_map[9]=50, free_preg[0]=9; pulse lasts exactly 1 cycle.
- rst asserted in the same cycle as commit rd=4 pd=60 -> map[4]=4; free_valid=0.
- RRAT_STATS_EN: 10 cycles of 2 valid commits, 3 of them with rd=0 -> retired_cnt=20, freed_cnt=17.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types and sizes for the commit/retirement path.
// The ROB builds rrat_commit_t from its commit entries. The free-list push path uses rrat_free_t.
package rv32i_types;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  localparam int AREG_W    = $clog2(ARCH_REGS);
  localparam int PREG_W    = $clog2(PHYS_REGS);

  typedef struct packed {
    logic              valid;
    logic              regf_we;
    logic [AREG_W-1:0] rd;
    logic [PREG_W-1:0] pd;
  } rrat_commit_t;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] preg;
  } rrat_free_t;

  function automatic logic [7:0] count_ones(input logic [63:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) n = n + {7'd0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/rrat_bundle_resolve.sv
// Per-slot resolution of one commit bundle. It selects the freed physical reg, forwarding from an
// older slot in the same bundle, and gates table writes so that only the youngest writer of each rd writes.
module rrat_bundle_resolve #(
  parameter int SS = 2,
  parameter int AW = 5,
  parameter int PW = 6
) (
  input  logic [SS-1:0]         valid,
  input  logic [SS-1:0]         regf_we,
  input  logic [SS-1:0][AW-1:0] rd,
  input  logic [SS-1:0][PW-1:0] pd,
  input  logic [SS-1:0][PW-1:0] old_preg,
  output logic [SS-1:0]         eff,
  output logic [SS-1:0]         wr_en,
  output logic [SS-1:0][PW-1:0] free_preg
);
  genvar gi;
  generate
    for (gi = 0; gi < SS; gi++) begin : g_eff
      assign eff[gi] = valid[gi] && regf_we[gi] && (rd[gi] != '0);
    end
  endgenerate

  // The ascending scan of older slots leaves the youngest matching older slot as the forwarding source.
  always_comb begin
    free_preg = old_preg;
    wr_en     = eff;
    for (int k = 0; k < SS; k++) begin
      for (int j = 0; j < SS; j++) begin
        if (j < k && eff[j] && rd[j] == rd[k]) free_preg[k] = pd[j];
        if (j > k && eff[j] && rd[j] == rd[k]) wr_en[k] = 1'b0;
      end
    end
  end
endmodule

// File: rtl/retirement_rat.sv
// Retirement RAT: holds committed arch->phys map, frees overwritten regs, publishes map after flush.
// Optional RRAT_STATS_EN adds saturating retired/freed counters.
module retirement_rat
  import rv32i_types::*;
#(
  parameter int SS        = 2,
  parameter int ARCH_REGS = rv32i_types::ARCH_REGS,
  parameter int PHYS_REGS = rv32i_types::PHYS_REGS,
  localparam int AW       = $clog2(ARCH_REGS),
  localparam int PW       = $clog2(PHYS_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SS-1:0]                commit_valid,
  input  logic [SS-1:0]                commit_regf_we,
  input  logic [SS-1:0][AW-1:0]        commit_rd,
  input  logic [SS-1:0][PW-1:0]        commit_pd,
  input  logic                         flush,
  output logic [SS-1:0]                free_valid,
  output logic [SS-1:0][PW-1:0]        free_preg,
  output logic                         restore_valid,
  output logic [ARCH_REGS-1:0][PW-1:0] restore_map
`ifdef RRAT_STATS_EN
  ,
  output logic [63:0]                  retired_cnt,
  output logic [63:0]                  freed_cnt
`endif
);
  logic [PW-1:0]         map_reg [ARCH_REGS];
  logic [SS-1:0][PW-1:0] old_preg;
  logic [SS-1:0]         eff;
  logic [SS-1:0]         wr_en;
  logic [SS-1:0][PW-1:0] sel_preg;
  logic [SS-1:0]         free_valid_reg;
  logic [SS-1:0][PW-1:0] free_preg_reg;
  logic                  restore_valid_reg;

  genvar gi;
  generate
    for (gi = 0; gi < SS; gi++) begin : g_slot
      assign old_preg[gi] = map_reg[commit_rd[gi]];
      // Slots whose pd is 0 cannot be distinguished from the reset mapping of x0.
      assert property (@(posedge clk) disable iff (rst) !(eff[gi] && commit_pd[gi] == '0))
        else $error("retirement_rat: effective commit with pd 0 in slot %0d", gi);
    end
    for (gi = 0; gi < ARCH_REGS; gi++) begin : g_view
      assign restore_map[gi] = map_reg[gi];
    end
  endgenerate

  rrat_bundle_resolve #(.SS(SS), .AW(AW), .PW(PW)) u_resolve (
    .valid     (commit_valid),
    .regf_we   (commit_regf_we),
    .rd        (commit_rd),
    .pd        (commit_pd),
    .old_preg  (old_preg),
    .eff       (eff),
    .wr_en     (wr_en),
    .free_preg (sel_preg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) map_reg[i] <= PW'(i);
      free_valid_reg    <= '0;
      free_preg_reg     <= '0;
      restore_valid_reg <= 1'b0;
    end else begin
      for (int k = 0; k < SS; k++) begin
        if (wr_en[k]) map_reg[commit_rd[k]] <= commit_pd[k];
        free_preg_reg[k] <= eff[k] ? sel_preg[k] : '0;
      end
      free_valid_reg    <= eff;
      restore_valid_reg <= flush;
    end
  end

  assign free_valid    = free_valid_reg;
  assign free_preg     = free_preg_reg;
  assign restore_valid = restore_valid_reg;

`ifdef RRAT_STATS_EN
  logic [63:0] retired_cnt_reg, freed_cnt_reg;
  logic [64:0] retired_sum_next, freed_sum_next;

  always_comb begin
    retired_sum_next = {1'b0, retired_cnt_reg} + 65'(count_ones(64'(commit_valid)));
    freed_sum_next   = {1'b0, freed_cnt_reg} + 65'(count_ones(64'(eff)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt_reg <= '0;
      freed_cnt_reg   <= '0;
    end else begin
      retired_cnt_reg <= retired_sum_next[64] ? '1 : retired_sum_next[63:0];
      freed_cnt_reg   <= freed_sum_next[64] ? '1 : freed_sum_next[63:0];
    end
  end

  assign retired_cnt = retired_cnt_reg;
  assign freed_cnt   = freed_cnt_reg;
`endif
endmodule

// File: tb/tb_retirement_rat.sv
// Directed bench for retirement_rat: commit and free, intra-bundle forwarding, flush restore and reset.
// It also covers the optional counters when RRAT_STATS_EN is defined.
module tb_retirement_rat;
  localparam int SS = 2;
  localparam int AW = 5;
  localparam int PW = 6;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [SS-1:0]         commit_valid;
  logic [SS-1:0]         commit_regf_we;
  logic [SS-1:0][AW-1:0] commit_rd;
  logic [SS-1:0][PW-1:0] commit_pd;
  logic                  flush;
  logic [SS-1:0]         free_valid;
  logic [SS-1:0][PW-1:0] free_preg;
  logic                  restore_valid;
  logic [31:0][PW-1:0]   restore_map;
`ifdef RRAT_STATS_EN
  logic [63:0]           retired_cnt, freed_cnt;
`endif

  int checks = 0;
  int errors = 0;

  retirement_rat #(.SS(SS), .ARCH_REGS(32), .PHYS_REGS(64)) dut (
    .clk            (clk),
    .rst            (rst),
    .commit_valid   (commit_valid),
    .commit_regf_we (commit_regf_we),
    .commit_rd      (commit_rd),
    .commit_pd      (commit_pd),
    .flush          (flush),
    .free_valid     (free_valid),
    .free_preg      (free_preg),
    .restore_valid  (restore_valid),
    .restore_map    (restore_map)
`ifdef RRAT_STATS_EN
    ,
    .retired_cnt    (retired_cnt),
    .freed_cnt      (freed_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle();
    commit_valid   = '0;
    commit_regf_we = '0;
    commit_rd      = '0;
    commit_pd      = '0;
    flush          = 1'b0;
  endtask

  task automatic slot(input int k, input logic we, input logic [AW-1:0] rd, input logic [PW-1:0] pd);
    commit_valid[k]   = 1'b1;
    commit_regf_we[k] = we;
    commit_rd[k]      = rd;
    commit_pd[k]      = pd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    check("reset_free_valid", 64'(free_valid), 64'd0);
    check("reset_restore_valid", 64'(restore_valid), 64'd0);
    check("reset_map0", 64'(restore_map[0]), 64'd0);
    check("reset_map5", 64'(restore_map[5]), 64'd5);
    check("reset_map31", 64'(restore_map[31]), 64'd31);

    // Single commit rd=5 pd=40
    slot(0, 1'b1, 5'd5, 6'd40);
    step();
    idle();
    $display("txn commit rd=5 pd=40: free_valid=%b free_preg0=%0d map5=%0d", free_valid, free_preg[0], restore_map[5]);
    check("c1_free_valid", 64'(free_valid), 64'b01);
    check("c1_free_preg0", 64'(free_preg[0]), 64'd5);
    check("c1_map5", 64'(restore_map[5]), 64'd40);
    step();
    check("c1_free_one_cycle", 64'(free_valid), 64'd0);

    // Same rd in both slots: forward slot0 pd, youngest wins the table
    slot(0, 1'b1, 5'd7, 6'd41);
    slot(1, 1'b1, 5'd7, 6'd42);
    step();
    idle();
    $display("txn dual rd=7: free_valid=%b free_preg=%0d,%0d map7=%0d", free_valid, free_preg[0], free_preg[1], restore_map[7]);
    check("c2_free_valid", 64'(free_valid), 64'b11);
    check("c2_free_preg0", 64'(free_preg[0]), 64'd7);
    check("c2_free_preg1", 64'(free_preg[1]), 64'd41);
    check("c2_map7", 64'(restore_map[7]), 64'd42);

    // Distinct rds: both free table values
    slot(0, 1'b1, 5'd5, 6'd44);
    slot(1, 1'b1, 5'd6, 6'd45);
    step();
    idle();
    $display("txn rd=5/6: free_preg=%0d,%0d", free_preg[0], free_preg[1]);
    check("c3_free_preg0", 64'(free_preg[0]), 64'd40);
    check("c3_free_preg1", 64'(free_preg[1]), 64'd6);
    check("c3_map5", 64'(restore_map[5]), 64'd44);
    check("c3_map6", 64'(restore_map[6]), 64'd45);

    // Non-effective slots: rd=0, and regf_we=0
    slot(0, 1'b1, 5'd0, 6'd43);
    slot(1, 1'b0, 5'd3, 6'd46);
    step();
    idle();
    $display("txn non-effective: free_valid=%b map0=%0d map3=%0d", free_valid, restore_map[0], restore_map[3]);
    check("c4_free_valid", 64'(free_valid), 64'd0);
    check("c4_map0", 64'(restore_map[0]), 64'd0);
    check("c4_map3", 64'(restore_map[3]), 64'd3);

    // Flush with a commit in the same cycle
    slot(0, 1'b1, 5'd9, 6'd50);
    flush = 1'b1;
    step();
    idle();
    $display("txn flush rd=9 pd=50: restore_valid=%b map9=%0d free_preg0=%0d", restore_valid, restore_map[9], free_preg[0]);
    check("f1_restore_valid", 64'(restore_valid), 64'd1);
    check("f1_map9", 64'(restore_map[9]), 64'd50);
    check("f1_free_valid", 64'(free_valid), 64'b01);
    check("f1_free_preg0", 64'(free_preg[0]), 64'd9);
    step();
    check("f1_pulse_end", 64'(restore_valid), 64'd0);

    // Back-to-back flushes
    slot(0, 1'b1, 5'd10, 6'd51);
    flush = 1'b1;
    step();
    idle();
    check("f2_restore_valid", 64'(restore_valid), 64'd1);
    slot(1, 1'b1, 5'd10, 6'd52);
    flush = 1'b1;
    step();
    idle();
    $display("txn flush2: restore_valid=%b free_valid=%b free_preg1=%0d map10=%0d", restore_valid, free_valid, free_preg[1], restore_map[10]);
    check("f3_restore_valid", 64'(restore_valid), 64'd1);
    check("f3_free_valid", 64'(free_valid), 64'b10);
    check("f3_free_preg1", 64'(free_preg[1]), 64'd51);
    check("f3_map10", 64'(restore_map[10]), 64'd52);
    step();
    check("f3_pulse_end", 64'(restore_valid), 64'd0);

    // Reset with a commit and a flush pending
    slot(0, 1'b1, 5'd4, 6'd60);
    flush = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle();
    $display("txn reset+commit rd=4: map4=%0d free_valid=%b restore_valid=%b", restore_map[4], free_valid, restore_valid);
    check("r1_map4", 64'(restore_map[4]), 64'd4);
    check("r1_map5", 64'(restore_map[5]), 64'd5);
    check("r1_free_valid", 64'(free_valid), 64'd0);
    check("r1_restore_valid", 64'(restore_valid), 64'd0);

`ifdef RRAT_STATS_EN
    check("s_reset_retired", retired_cnt, 64'd0);
    check("s_reset_freed", freed_cnt, 64'd0);
    for (int i = 0; i < 10; i++) begin
      slot(0, 1'b1, 5'(1 + i), 6'(33 + i));
      slot(1, 1'b1, (i < 3) ? 5'd0 : 5'(20 + i), 6'(44 + i));
      step();
    end
    idle();
    $display("txn stats: retired_cnt=%0d freed_cnt=%0d", retired_cnt, freed_cnt);
    check("s_retired", retired_cnt, 64'd20);
    check("s_freed", freed_cnt, 64'd17);
    step();
    check("s_retired_hold", retired_cnt, 64'd20);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
